alu_exec_stage: RTL and testbench

//   Registered execute stage that consumes the 4-bit alu_control code from the
//   ALU control unit, plus two operands. It computes the result and zero flag
//   and holds them in a 2-entry output buffer. A valid/ready handshake on both

---
 rtl/alu_exec_stage.sv | 116 +++++++++++
 tb/tb_alu_exec_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry result buffer and valid/ready on both sides.
// Define ALU_OVF_EN to add the per-entry signed overflow flag and the overflow port.
module alu_exec_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;

  buf_state_t state_q;
  entry_t     head_q;
  entry_t     second_q;
  entry_t     ent_d;
  logic       accept_s;
  logic       pop_s;

  // ALU result for the operands currently presented upstream
  always_comb begin
    ent_d = '0;
    case (alu_control)
      OP_ADD:  ent_d.res = a + b;
      OP_SUB:  ent_d.res = a - b;
      OP_AND:  ent_d.res = a & b;
      OP_OR:   ent_d.res = a | b;
      OP_SLT:  ent_d.res = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: ent_d.res = '0;
    endcase
    ent_d.zero = (ent_d.res == '0);
`ifdef ALU_OVF_EN
    case (alu_control)
      OP_ADD:  ent_d.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (ent_d.res[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  ent_d.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (ent_d.res[WIDTH-1] != a[WIDTH-1]);
      default: ent_d.ovf = 1'b0;
    endcase
`endif
  end

  // in_ready depends only on registered state, so out_ready never reaches it combinationally
  assign in_ready  = (state_q != buf_state_t'(FULL_CNT));
  assign out_valid = (state_q != EMPTY);
  assign accept_s  = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Buffer occupancy and entry storage; a push into ONE during a pop replaces the head directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      second_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            head_q  <= ent_d;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            head_q <= ent_d;
          end else if (accept_s) begin
            second_q <= ent_d;
            state_q  <= FULL;
          end else if (pop_s) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_q  <= second_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign result = head_q.res;
  assign zero   = head_q.zero;
`ifdef ALU_OVF_EN
  assign overflow = head_q.ovf;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expected results queued on accept, compared on output.
module tb_alu_exec_stage;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  exp_t q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   run_len = 0;
  int   cyc     = 0;

  alu_exec_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
`ifdef ALU_OVF_EN
    , .overflow(overflow)
`endif
  );

`ifndef ALU_OVF_EN
  assign overflow = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    e.ovf = 1'b0;
    case (op)
      4'b0010: begin
        e.res = av + bv;
        e.ovf = (av[W-1] == bv[W-1]) && (e.res[W-1] != av[W-1]);
      end
      4'b0110: begin
        e.res = av - bv;
        e.ovf = (av[W-1] != bv[W-1]) && (e.res[W-1] != av[W-1]);
      end
      4'b0000: e.res = av & bv;
      4'b0001: e.res = av | bv;
      4'b0111: e.res = ($signed(av) < $signed(bv)) ? 64'd1 : 64'd0;
      default: e.res = 64'd0;
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  // Output monitor: head must match the oldest expected entry, whether popped or stalled
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check_val("spurious_out", 64'd1, 64'd0);
        end else begin
          check_val("result", result, q[0].res);
          check_val("zero", {63'd0, zero}, {63'd0, q[0].zero});
`ifdef ALU_OVF_EN
          check_val("overflow", {63'd0, overflow}, {63'd0, q[0].ovf});
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
      run_len = (out_valid && out_ready) ? run_len + 1 : 0;
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    bit done = 1'b0;
    in_valid = 1'b1; alu_control = op; a = av; b = bv;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(op, av, bv));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check_val("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    check_val("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    reset = 1'b1; in_valid = 1'b0; alu_control = 4'd0; a = '0; b = '0; out_ready = 1'b1;
    @(negedge clk);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_result", result, 64'd0);
    check_val("rst_zero", {63'd0, zero}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    send(4'b0010, 64'd5, 64'd7);
    send(4'b0110, 64'd7, 64'd7);
    send(4'b0111, {W{1'b1}}, 64'd1);
    send(4'b0111, 64'd1, {W{1'b1}});
    send(4'b0000, 64'hF0F0, 64'hFF00);
    send(4'b0001, 64'hF0F0, 64'hFF00);
    send(4'b1111, 64'd3, 64'd4);
    send(4'b0011, 64'd0, 64'd0);
    send(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    send(4'b0110, 64'h8000_0000_0000_0000, 64'd1);
    send(4'b0000, 64'h8000_0000_0000_0000, {W{1'b1}});
    send(4'b0010, {W{1'b1}}, 64'd1);
    drain();

    out_ready = 1'b0;
    send(4'b0010, 64'd1, 64'd1);
    send(4'b0110, 64'd9, 64'd4);
    @(negedge clk);
    check_val("full_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(4'b0010, 64'(i * 3), 64'(100 + i));
    check_val("stream_cycles", 64'(cyc - c0), 64'd8);
    @(negedge clk); #2;
    check_val("stream_run_len", 64'(run_len), 64'd8);
    drain();

    out_ready = 1'b0;
    send(4'b0010, 64'd11, 64'd22);
    send(4'b0001, 64'd1, 64'd2);
    reset = 1'b1; in_valid = 1'b1; alu_control = 4'b0010; a = 64'd3; b = 64'd4;
    q.delete();
    @(negedge clk);
    check_val("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("midrst_result", result, 64'd0);
    check_val("midrst_zero", {63'd0, zero}, 64'd0);
    check_val("midrst_overflow", {63'd0, overflow}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_val("rel_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rel_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(4'b0110, 64'd100, 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
